seq_mul_controller: RTL



---
 rtl/seq_mul_controller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seq_mul_controller.sv
// rtl/seq_mul_controller.sv - radix-2 Booth sequential multiplier control FSM with watchdog
// Drives load enables, mux selects and ALU op for an external multiplier datapath.
module seq_mul_controller #(
  parameter int N_ITER   = 16,
  parameter int WD_LIMIT = N_ITER + 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       src_valid,
  output logic       src_ready,
  output logic       dst_valid,
  input  logic       dst_ready,
  input  logic       count_done,
  input  logic       Q0,
  input  logic       Q_1,
  output logic       en_mltd,
  output logic       en_multr,
  output logic       en_ac,
  output logic       en_count,
  output logic       selQ,
  output logic       selA,
  output logic       selQ_1,
  output logic [1:0] alu_op,
  output logic       en_out,
  output logic       clear,
  output logic       busy,
  output logic       err
);

  localparam int WD_W = $clog2(WD_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  logic [WD_W-1:0] r_wd;
  logic            w_wd_last;

  // The CALC cycle that brings the watchdog to WD_LIMIT is the last one allowed.
  assign w_wd_last = (r_wd == WD_W'(WD_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (src_valid) r_state <= S_LOAD;
        S_LOAD: begin
          r_wd    <= '0;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_wd <= r_wd + WD_W'(1);
          if (count_done)     r_state <= S_DONE;
          else if (w_wd_last) r_state <= S_ERR;
        end
        S_DONE: if (dst_ready) r_state <= S_IDLE;
        S_ERR:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from state, with rst_n gating so reset values appear immediately.
  always_comb begin
    src_ready = 1'b0;
    dst_valid = 1'b0;
    en_mltd   = 1'b0;
    en_multr  = 1'b0;
    en_ac     = 1'b0;
    en_count  = 1'b0;
    selQ      = 1'b0;
    selA      = 1'b0;
    selQ_1    = 1'b0;
    alu_op    = 2'b00;
    en_out    = 1'b1;
    clear     = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          src_ready = 1'b1;
          clear     = src_valid;
        end
        S_LOAD: begin
          en_mltd  = 1'b1;
          en_multr = 1'b1;
          en_ac    = 1'b1;
          busy     = 1'b1;
        end
        S_CALC: begin
          en_out = 1'b0;
          busy   = 1'b1;
          if (!count_done) begin
            en_multr = 1'b1;
            en_ac    = 1'b1;
            en_count = 1'b1;
            selQ     = 1'b1;
            selA     = 1'b1;
            selQ_1   = 1'b1;
            case ({Q0, Q_1})
              2'b10:   alu_op = 2'b10;
              2'b01:   alu_op = 2'b01;
              default: alu_op = 2'b00;
            endcase
          end
        end
        S_DONE: begin
          en_out    = 1'b0;
          dst_valid = 1'b1;
          busy      = 1'b1;
        end
        S_ERR: begin
          err   = 1'b1;
          clear = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
